led_pwm_sched: RTL and testbench
================================

LED_PWM_SCHED -- requirements
Module: led_pwm_sched

Interface
REQ-001 SHALL have parameter PRESCALE, default 196, meaning clk cycles per PWM step (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wr_valid  input  1  a register write is offered this cycle.
REQ-005 SHALL have port wr_ready  output  1  the write is accepted this cycle.
REQ-006 SHALL have port wr_addr  input  4  register address.
REQ-007 SHALL have port wr_data  input  8  register write data.
REQ-008 SHALL have port led  output  12  LED drive; [3:0] R, [7:4] G, [11:8] B of LEDs 0..3.
REQ-009 SHALL have port frame  output  1  one-cycle pulse at each PWM period wrap.

Function
REQ-010 A write SHALL transfer only on a cycle where wr_valid=1 and wr_ready=1.
REQ-011 Address 0..11 SHALL write duty[addr] = wr_data.
REQ-012 Address 12 SHALL write ctrl: bit0 = enable, bit1 = invert; bits 7:2 ignored.
REQ-013 Address 13..15 SHALL be accepted and discarded with no state change.
REQ-014 Prescaler pcnt SHALL count 0..PRESCALE-1 and wrap to 0; step = (pcnt == PRESCALE-1).
REQ-015 The 8-bit pwm_cnt SHALL increment on step and wrap from 255 to 0.
REQ-016 A load cycle SHALL be the cycle where step=1 and pwm_cnt=255.
REQ-017 On a load cycle, every shadow[i] SHALL take duty[i] and shadow enable/invert SHALL take ctrl, so duty changes take effect only at a period boundary (glitch-free).
REQ-018 wr_ready SHALL be 1 on every cycle except a load cycle, where it SHALL be 0; a write held across the load cycle is accepted on the next cycle, and that data appears in the following period.
REQ-019 raw[i] SHALL be (pwm_cnt < shadow[i]): duty 0 gives always off, duty 255 gives on 255 of 256 steps.
REQ-020 led[i] SHALL be registered: led[i] <= shadow_en ? (raw[i] XOR shadow_inv) : 0.
REQ-021 LED output latency SHALL be exactly 1 clk after pwm_cnt/shadow state.
REQ-022 frame SHALL be registered and high for exactly the one cycle after each load cycle.
REQ-023 wr_valid/wr_addr/wr_data SHALL be ignored while wr_ready=0; no buffering.
REQ-024 Period length SHALL be exactly 256*PRESCALE clk cycles; no drift and no skipped step.

Reset
REQ-025 While reset=1, all of the following SHALL clear to 0 asynchronously: pcnt, pwm_cnt, duty[0..11], shadow[0..11], ctrl, shadow ctrl, led, frame.
REQ-026 While reset=1, wr_ready SHALL be 0.
REQ-027 After reset deasserts, the first step SHALL occur on the PRESCALE-th rising clk edge.
REQ-028 While reset=1, the block SHALL accept no write.
REQ-029 Reset mid-period SHALL abandon the period; led=0 until enable is rewritten and a load cycle occurs.

Verification
REQ-030 Bench (PRESCALE=2): reset; write ctrl=0x01 and duty[0]=128; wait for frame; led[0] SHALL be high 256 clk then low 256 clk per 512-clk period, and all other leds SHALL be 0.
REQ-031 Bench: duty[4]=0 and duty[8]=255 with enable set -> led[4] SHALL stay 0; led[8] SHALL be low exactly 2 clk (one step) per period.
REQ-032 Bench: ctrl=0x03 and duty[1]=64 -> led[1] SHALL be low 128 clk and high 384 clk per period.
REQ-033 Bench: hold wr_valid=1 across a load cycle -> wr_ready=0 for exactly that cycle; the write SHALL be accepted on the next cycle; the new duty SHALL appear one period later; frame SHALL pulse once.
REQ-034 Bench: change duty[2] from 200 to 10 mid-period -> the current period SHALL complete with 200, and the next period SHALL use 10 with no extra pulse.
REQ-035 Bench: assert reset mid-period for 3 clk -> led=0, frame=0 and wr_ready=0 immediately; after release, led SHALL stay 0 until enable is rewritten and the next frame occurs.

Source files
------------

// File: rtl/led_pwm_sched.sv
// led_pwm_sched: 12-channel LED PWM with double-buffered duty registers.
// Duty and control registers are written at any time. They are copied into
// shadow registers only at the period boundary, so every PWM period runs
// with one consistent set of values and never shows a partial pulse.
module led_pwm_sched #(
  parameter int unsigned PRESCALE = 196
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [11:0] led,
  output logic        frame
);

  localparam int unsigned NUM_CH   = 12;
  localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);
  localparam logic [3:0]  CTRL_ADDR = 4'd12;

  logic [15:0] pcnt_q, pcnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_q   [NUM_CH];
  logic [7:0]  duty_d   [NUM_CH];
  logic [7:0]  shadow_q [NUM_CH];
  logic [7:0]  shadow_d [NUM_CH];
  logic        ctrl_en_q, ctrl_en_d;
  logic        ctrl_inv_q, ctrl_inv_d;
  logic        shadow_en_q, shadow_en_d;
  logic        shadow_inv_q, shadow_inv_d;
  logic [11:0] led_q, led_d;
  logic        frame_q, frame_d;

  logic step;
  logic load;
  logic wr_fire;

  // Step and load strobes; the write port is closed during reset and on the
  // single load cycle so a shadow copy never races with a register write.
  always_comb begin
    step     = (pcnt_q == PCNT_MAX);
    load     = step && (pwm_cnt_q == 8'hFF);
    wr_ready = !reset && !load;
    wr_fire  = wr_valid && wr_ready;
  end

  // Next-state logic for the timebase, register file, shadows and outputs.
  always_comb begin
    pcnt_d       = pcnt_q;
    pwm_cnt_d    = pwm_cnt_q;
    duty_d       = duty_q;
    shadow_d     = shadow_q;
    ctrl_en_d    = ctrl_en_q;
    ctrl_inv_d   = ctrl_inv_q;
    shadow_en_d  = shadow_en_q;
    shadow_inv_d = shadow_inv_q;
    led_d        = '0;
    frame_d      = load;

    if (step) begin
      pcnt_d    = '0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      pcnt_d = pcnt_q + 16'd1;
    end

    if (wr_fire) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == 4'(i)) begin
          duty_d[i] = wr_data;
        end
      end
      if (wr_addr == CTRL_ADDR) begin
        ctrl_en_d  = wr_data[0];
        ctrl_inv_d = wr_data[1];
      end
    end

    if (load) begin
      shadow_d     = duty_q;
      shadow_en_d  = ctrl_en_q;
      shadow_inv_d = ctrl_inv_q;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      led_d[i] = shadow_en_q && ((pwm_cnt_q < shadow_q[i]) ^ shadow_inv_q);
    end
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q       <= '0;
      pwm_cnt_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      ctrl_en_q    <= 1'b0;
      ctrl_inv_q   <= 1'b0;
      shadow_en_q  <= 1'b0;
      shadow_inv_q <= 1'b0;
      led_q        <= '0;
      frame_q      <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      shadow_q     <= shadow_d;
      ctrl_en_q    <= ctrl_en_d;
      ctrl_inv_q   <= ctrl_inv_d;
      shadow_en_q  <= shadow_en_d;
      shadow_inv_q <= shadow_inv_d;
      led_q        <= led_d;
      frame_q      <= frame_d;
    end
  end

  assign led   = led_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_led_pwm_sched.sv
// Testbench for led_pwm_sched with PRESCALE=2 (512-clk PWM period).
module tb_led_pwm_sched;

  localparam int PERIOD = 512;

  typedef struct {
    logic [11:0] led;
    logic        frame;
    logic        ready;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] led;
  logic        frame;

  int total;
  int bad;

  // Reference register state: m_* is the written state, n_* the state the
  // next period will load into its shadows.
  logic [7:0] m_duty [12];
  logic [7:0] n_duty [12];
  logic       m_en, m_inv, n_en, n_inv;
  int         period_hi [12];
  int         accept_k;
  exp_t       sb [$];

  led_pwm_sched #(.PRESCALE(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .led      (led),
    .frame    (frame)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the bench always ends even if a task gets stuck.
  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void apply_write(input logic [3:0] a, input logic [7:0] d);
    if (a < 4'd12) m_duty[a] = d;
    else if (a == 4'd12) begin
      m_en  = d[0];
      m_inv = d[1];
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 12; i++) begin
      m_duty[i] = 8'd0;
      n_duty[i] = 8'd0;
    end
    m_en = 1'b0; m_inv = 1'b0; n_en = 1'b0; n_inv = 1'b0;
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    bit accepted;
    accepted = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int t = 0; t < 8; t++) begin
      if (wr_ready === 1'b1) begin
        accepted = 1;
        apply_write(a, d);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    total++;
    if (!accepted) begin
      bad++;
      $display("[TB] FAIL write_accept addr=%0d: got accepted=0 want accepted=1", a);
    end
  endtask

  task automatic wait_frame(input string tag);
    bit found;
    found = 0;
    for (int n = 0; n < 1100; n++) begin
      @(negedge clk);
      if (frame === 1'b1) begin
        found = 1;
        break;
      end
    end
    n_duty = m_duty;
    n_en   = m_en;
    n_inv  = m_inv;
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL %s wait_frame: got no frame want frame within 1100 clk", tag);
    end
  endtask

  // Leaves the bench at the negedge of the first frame cycle after release.
  task automatic first_frame_after_release(input string tag);
    int  n;
    bit  led_seen;
    led_seen = 0;
    for (n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (led !== 12'h000) led_seen = 1;
      if (frame === 1'b1) break;
    end
    n_duty = m_duty;
    n_en   = m_en;
    n_inv  = m_inv;
    total++;
    if (n != PERIOD) begin
      bad++;
      $display("[TB] FAIL %s first_frame: got cycle=%0d want cycle=%0d", tag, n, PERIOD);
    end
    total++;
    if (led_seen) begin
      bad++;
      $display("[TB] FAIL %s led_after_reset: got nonzero led want 0", tag);
    end
  endtask

  // Checks one full period starting right after a frame cycle. An optional
  // write (wr_at >= 0) is offered from cycle wr_at and held until accepted.
  task automatic check_period(input int wr_at, input logic [3:0] wa,
                              input logic [7:0] wd, input string tag);
    logic [7:0]  s_duty [12];
    logic        s_en, s_inv;
    logic [11:0] el;
    exp_t        e;
    int          pwm;
    bit          pend, done;

    s_duty = n_duty;
    s_en   = n_en;
    s_inv  = n_inv;
    for (int i = 0; i < 12; i++) period_hi[i] = 0;

    for (int k = 0; k < PERIOD; k++) begin
      pwm = k / 2;
      for (int i = 0; i < 12; i++) begin
        el[i] = s_en ? ((pwm < int'(s_duty[i])) ^ s_inv) : 1'b0;
      end
      e.led   = el;
      e.frame = (k == PERIOD - 1);
      e.ready = (k != PERIOD - 2);
      sb.push_back(e);
    end

    pend = (wr_at >= 0);
    done = 0;
    accept_k = -1;

    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (led !== e.led) begin
        bad++;
        $display("[TB] FAIL %s led k=%0d: got=%h want=%h", tag, k, led, e.led);
      end
      total++;
      if (frame !== e.frame) begin
        bad++;
        $display("[TB] FAIL %s frame k=%0d: got=%b want=%b", tag, k, frame, e.frame);
      end
      total++;
      if (wr_ready !== e.ready) begin
        bad++;
        $display("[TB] FAIL %s wr_ready k=%0d: got=%b want=%b", tag, k, wr_ready, e.ready);
      end
      for (int i = 0; i < 12; i++) if (led[i] === 1'b1) period_hi[i]++;

      if (k == PERIOD - 2) begin
        n_duty = m_duty;
        n_en   = m_en;
        n_inv  = m_inv;
      end

      if (done && wr_valid) wr_valid = 1'b0;
      if (pend && k >= wr_at) begin
        wr_valid = 1'b1;
        wr_addr  = wa;
        wr_data  = wd;
        if (wr_ready === 1'b1) begin
          apply_write(wa, wd);
          pend = 0;
          done = 1;
          accept_k = k;
        end
      end
    end

    if (done && wr_valid) begin
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
    end
    if (pend) begin
      wr_valid = 1'b0;
      total++;
      bad++;
      $display("[TB] FAIL %s period_write: got not accepted want accepted", tag);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 8'd0;
    clear_model();
    #1;
    total++;
    if (led !== 12'h000 || frame !== 1'b0 || wr_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got led=%h frame=%b ready=%b want 000/0/0",
               led, frame, wr_ready);
    end
    // Writes offered during reset must be refused.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_addr  = 4'd12;
      wr_data  = 8'h01;
      #1;
      total++;
      if (wr_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_ready c=%0d: got=%b want=0", c, wr_ready);
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    reset    = 1'b0;
    first_frame_after_release("reset");
    check_period(-1, 4'd0, 8'd0, "reset_idle");
  endtask

  task automatic test_basic();
    do_write(4'd12, 8'h01);
    do_write(4'd0, 8'd128);
    wait_frame("basic");
    check_period(-1, 4'd0, 8'd0, "basic");
    total++;
    if (period_hi[0] != 256) begin
      bad++;
      $display("[TB] FAIL basic_hi0: got=%0d want=256", period_hi[0]);
    end
  endtask

  task automatic test_extremes();
    do_write(4'd4, 8'd0);
    do_write(4'd8, 8'd255);
    do_write(4'd13, 8'hFF);
    do_write(4'd15, 8'h00);
    wait_frame("extremes");
    check_period(-1, 4'd0, 8'd0, "extremes");
    total++;
    if (period_hi[4] != 0) begin
      bad++;
      $display("[TB] FAIL extremes_hi4: got=%0d want=0", period_hi[4]);
    end
    total++;
    if (period_hi[8] != PERIOD - 2) begin
      bad++;
      $display("[TB] FAIL extremes_hi8: got=%0d want=%0d", period_hi[8], PERIOD - 2);
    end
  endtask

  task automatic test_invert();
    do_write(4'd12, 8'h03);
    do_write(4'd1, 8'd64);
    wait_frame("invert");
    check_period(-1, 4'd0, 8'd0, "invert");
    total++;
    if (period_hi[1] != 384) begin
      bad++;
      $display("[TB] FAIL invert_hi1: got=%0d want=384", period_hi[1]);
    end
  endtask

  task automatic test_midchange();
    do_write(4'd12, 8'hFD);
    do_write(4'd2, 8'd200);
    wait_frame("midchange");
    check_period(100, 4'd2, 8'd10, "midchange_old");
    total++;
    if (period_hi[2] != 400) begin
      bad++;
      $display("[TB] FAIL midchange_hi2_old: got=%0d want=400", period_hi[2]);
    end
    check_period(-1, 4'd0, 8'd0, "midchange_new");
    total++;
    if (period_hi[2] != 20) begin
      bad++;
      $display("[TB] FAIL midchange_hi2_new: got=%0d want=20", period_hi[2]);
    end
  endtask

  task automatic test_back_to_back();
    check_period(PERIOD - 2, 4'd0, 8'd32, "b2b_hold");
    total++;
    if (accept_k != PERIOD - 1) begin
      bad++;
      $display("[TB] FAIL b2b_accept: got k=%0d want k=%0d", accept_k, PERIOD - 1);
    end
    check_period(-1, 4'd0, 8'd0, "b2b_same");
    total++;
    if (period_hi[0] != 256) begin
      bad++;
      $display("[TB] FAIL b2b_hi0_same: got=%0d want=256", period_hi[0]);
    end
    check_period(-1, 4'd0, 8'd0, "b2b_new");
    total++;
    if (period_hi[0] != 64) begin
      bad++;
      $display("[TB] FAIL b2b_hi0_new: got=%0d want=64", period_hi[0]);
    end
  endtask

  task automatic test_reset_mid();
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (led !== 12'h000 || frame !== 1'b0 || wr_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_now: got led=%h frame=%b ready=%b want 000/0/0",
               led, frame, wr_ready);
    end
    clear_model();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (led !== 12'h000 || frame !== 1'b0 || wr_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_mid_hold c=%0d: got led=%h frame=%b ready=%b want 000/0/0",
                 c, led, frame, wr_ready);
      end
    end
    reset = 1'b0;
    first_frame_after_release("reset_mid");
    check_period(-1, 4'd0, 8'd0, "reset_mid_idle");
    do_write(4'd12, 8'h01);
    do_write(4'd3, 8'd100);
    wait_frame("reset_mid_restart");
    check_period(-1, 4'd0, 8'd0, "reset_mid_restart");
    total++;
    if (period_hi[3] != 200 || period_hi[0] != 0) begin
      bad++;
      $display("[TB] FAIL reset_mid_hi: got hi3=%0d hi0=%0d want hi3=200 hi0=0",
               period_hi[3], period_hi[0]);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_invert();
    test_midchange();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
